// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encoding and the wrap/clamp arithmetic
// used to compute the next count of a modulo-N up/down counter.
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Counters of any width up to CNT_MAX_W share these helpers by zero-extending.
  localparam int CNT_MAX_W = 32;
  typedef logic [CNT_MAX_W-1:0] cnt_t;

  // One enabled step with wrap-around at the ends of the 0..last range.
  function automatic cnt_t cnt_wrap_step(input cnt_t cur, input logic up_dn, input cnt_t last);
    if (up_dn == CNT_UP) begin
      return (cur == last) ? '0 : cur + cnt_t'(1);
    end
    return (cur == '0) ? last : cur - cnt_t'(1);
  endfunction

  // Out-of-range load values saturate to the top of the range.
  function automatic cnt_t cnt_clamp(input cnt_t val, input cnt_t last);
    return (val > last) ? last : val;
  endfunction

endpackage

// File: rtl/seq_counter_next.sv
// Combinational next-state and terminal-count logic for seq_counter.
module seq_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             tc
);

  localparam cnt_t LAST = cnt_t'(MODULO - 1);

  cnt_t count_ext;
  cnt_t load_ext;

  assign count_ext = cnt_t'(count);
  assign load_ext  = cnt_t'(load_val);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_count = count;
    tc         = 1'b0;
    if (load) begin
      next_count = WIDTH'(cnt_clamp(load_ext, LAST));
    end else if (en) begin
      next_count = WIDTH'(cnt_wrap_step(count_ext, up_dn, LAST));
      tc         = (up_dn == CNT_UP) ? (count_ext == LAST) : (count_ext == '0);
    end
  end

endmodule

// File: rtl/seq_counter.sv
// Modulo-N up/down counter with parallel load, count enable and terminal count.
// Holds only the state register; the arithmetic lives in seq_counter_next.
module seq_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] next_count;
  logic             tc_raw;

  seq_counter_next #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next (
    .count      (count),
    .en         (en),
    .up_dn      (up_dn),
    .load       (load),
    .load_val   (load_val),
    .next_count (next_count),
    .tc         (tc_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignment keeps register updates race-free across processes.
    if (!reset) begin
      count <= WIDTH'(RESET_VAL);
    end else begin
      count <= next_count;
    end
  end

  // Reset holds count at RESET_VAL, which may itself be a terminal value.
  assign tc = reset & tc_raw;

endmodule

// File: tb/tb_seq_counter.sv
// Self-checking bench for seq_counter: default modulo-16 instance plus a modulo-10 instance.
module tb_seq_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val, count;
  logic       tc;

  logic       reset10, en10, up_dn10, load10;
  logic [3:0] load_val10, count10;
  logic       tc10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_counter dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc)
  );

  seq_counter #(.WIDTH(4), .MODULO(10), .RESET_VAL(0)) dut10 (
    .clk      (clk),
    .reset    (reset10),
    .en       (en10),
    .up_dn    (up_dn10),
    .load     (load10),
    .load_val (load_val10),
    .count    (count10),
    .tc       (tc10)
  );

  typedef struct {
    logic       load;
    logic       en;
    logic       up_dn;
    logic [3:0] load_val;
    logic       exp_tc;     // tc before the edge
    logic [3:0] exp_count;  // count after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic ld, input logic e, input logic ud,
                              input logic [3:0] lv, input logic t, input logic [3:0] c);
    vec_t v;
    v.load = ld; v.en = e; v.up_dn = ud; v.load_val = lv; v.exp_tc = t; v.exp_count = c;
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
    reset10 = 1'b1; en10 = 1'b0; up_dn10 = 1'b1; load10 = 1'b0; load_val10 = '0;

    // Reset asserted mid-cycle must act without a clock edge.
    @(posedge clk);
    #2;
    reset = 1'b0; reset10 = 1'b0;
    #1;
    check("reset_async", count, 0);
    check("reset_async10", count10, 0);
    up_dn = 1'b0;
    #1;
    check("tc_in_reset", tc, 0);
    up_dn = 1'b1;
    #1;
    reset = 1'b1; reset10 = 1'b1;

    // Free run up through the terminal value and the wrap.
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("free_run_%0d", i), count, i);
    end
    check("free_run_tc15", tc, 1);
    step();
    check("free_run_wrap", count, 0);
    check("free_run_tc0", tc, 0);

    // Async reset during operation, held across edges.
    repeat (9) step();
    check("pre_reset_9", count, 9);
    #2;
    reset = 1'b0;
    #1;
    check("midop_reset", count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold_%0d", i), count, 0);
    end
    reset = 1'b1;

    // Table: down-count wrap, load priority, hold and direction switching.
    add(1, 0, 1, 4'd2,  0, 4'd2);
    add(0, 1, 0, 4'd0,  0, 4'd1);
    add(0, 1, 0, 4'd0,  0, 4'd0);
    add(0, 1, 0, 4'd0,  1, 4'd15);
    add(0, 1, 0, 4'd0,  0, 4'd14);
    add(1, 0, 0, 4'd5,  0, 4'd5);
    add(1, 1, 1, 4'd12, 0, 4'd12);
    add(1, 1, 0, 4'd7,  0, 4'd7);
    add(0, 0, 1, 4'd0,  0, 4'd7);
    add(0, 0, 1, 4'd0,  0, 4'd7);
    add(0, 0, 1, 4'd0,  0, 4'd7);
    add(0, 0, 1, 4'd0,  0, 4'd7);
    add(0, 1, 1, 4'd0,  0, 4'd8);
    add(0, 1, 0, 4'd0,  0, 4'd7);
    add(0, 1, 1, 4'd0,  0, 4'd8);
    add(1, 0, 1, 4'd15, 0, 4'd15);
    add(0, 0, 1, 4'd0,  0, 4'd15);
    add(0, 1, 1, 4'd0,  1, 4'd0);
    add(1, 1, 0, 4'd3,  0, 4'd3);

    foreach (vecs[i]) begin
      load = vecs[i].load; en = vecs[i].en; up_dn = vecs[i].up_dn; load_val = vecs[i].load_val;
      #1;
      check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
      step();
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
    end

    // Modulo-10 instance: full cycle, wrap and clamped loads.
    en10 = 1'b1;
    #1;
    for (int i = 0; i <= 9; i++) begin
      check($sformatf("mod10_count_%0d", i), count10, i);
      check($sformatf("mod10_tc_%0d", i), tc10, (i == 9) ? 1 : 0);
      step();
    end
    check("mod10_wrap", count10, 0);
    load10 = 1'b1; load_val10 = 4'd13;
    step();
    check("mod10_clamp13", count10, 9);
    #1;
    check("mod10_tc_load", tc10, 0);
    load_val10 = 4'd10;
    step();
    check("mod10_clamp10", count10, 9);
    load_val10 = 4'd5;
    step();
    check("mod10_load5", count10, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
